// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives L1 I-cache requests, buffers an
// instruction across decode stalls and applies branch redirects, including
// redirects that arrive while a miss is outstanding.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_target_i,
  input  logic             halt_i,
  output logic             icache_req_o,
  output logic [31:0]      icache_addr_o,
  input  logic             icache_ack_i,
  input  logic [31:0]      icache_data_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_add4_o,
  output logic [31:0]      inst_o,
  output logic             inst_valid_o,
  output logic             mem_stall_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] miss_cycles_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        buf_inst_q, buf_inst_d;
  logic               redir_pend_q, redir_pend_d;
  logic [31:0]        redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic               halt_pend_q, halt_pend_d;

  // Handshake: a request is held with a stable address while icache_req_o=1
  // and icache_ack_i=0; the word is consumed in the cycle req and ack are both high.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_inst_d   = buf_inst_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    miss_cnt_d   = miss_cnt_q;
    halt_pend_d  = halt_pend_q;
    icache_req_o = 1'b0;
    inst_o       = 32'h0;
    inst_valid_o = 1'b0;
    mem_stall_o  = 1'b0;
    flush_o      = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = halt_i ? HALTED : REQ;
      end

      REQ: begin
        icache_req_o = 1'b1;
        if (!icache_ack_i) begin
          mem_stall_o = 1'b1;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          if (halt_i) begin
            halt_pend_d = 1'b1;
          end else if (branch_i && !halt_pend_q) begin
            // Remember the target; the miss in flight must still be drained.
            flush_o      = 1'b1;
            redir_pend_d = 1'b1;
            redir_pc_d   = branch_target_i;
          end
        end else if (halt_i || halt_pend_q) begin
          state_d      = HALTED;
          halt_pend_d  = 1'b0;
          redir_pend_d = 1'b0;
        end else if (branch_i) begin
          // A fresh branch supersedes any pending one.
          flush_o      = 1'b1;
          pc_d         = branch_target_i;
          redir_pend_d = 1'b0;
        end else if (redir_pend_q) begin
          pc_d         = redir_pc_q;
          redir_pend_d = 1'b0;
        end else begin
          inst_o       = icache_data_i;
          inst_valid_o = 1'b1;
          if (stall_i) begin
            buf_inst_d = icache_data_i;
            state_d    = HOLD;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end

      HOLD: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (branch_i) begin
          flush_o = 1'b1;
          pc_d    = branch_target_i;
          state_d = REQ;
        end else begin
          inst_o       = buf_inst_q;
          inst_valid_o = 1'b1;
          if (!stall_i) begin
            pc_d    = pc_q + 32'd4;
            state_d = REQ;
          end
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      buf_inst_q   <= 32'h0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'h0;
      miss_cnt_q   <= '0;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      buf_inst_q   <= buf_inst_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      miss_cnt_q   <= miss_cnt_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  assign icache_addr_o = pc_q;
  assign pc_o          = pc_q;
  assign pc_add4_o     = pc_q + 32'd4;
  assign miss_cycles_o = miss_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: hits, miss, decode stall, redirects,
// PC wrap, halt during a miss and asynchronous reset.
module tb_fetch_unit;

  localparam int CNT_W = 16;

  logic             clk_i;
  logic             rst_i;
  logic             stall_i;
  logic             branch_i;
  logic [31:0]      branch_target_i;
  logic             halt_i;
  logic             icache_req_o;
  logic [31:0]      icache_addr_o;
  logic             icache_ack_i;
  logic [31:0]      icache_data_i;
  logic [31:0]      pc_o;
  logic [31:0]      pc_add4_o;
  logic [31:0]      inst_o;
  logic             inst_valid_o;
  logic             mem_stall_o;
  logic             flush_o;
  logic [CNT_W-1:0] miss_cycles_o;

  int checks;
  int errors;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .halt_i          (halt_i),
    .icache_req_o    (icache_req_o),
    .icache_addr_o   (icache_addr_o),
    .icache_ack_i    (icache_ack_i),
    .icache_data_i   (icache_data_i),
    .pc_o            (pc_o),
    .pc_add4_o       (pc_add4_o),
    .inst_o          (inst_o),
    .inst_valid_o    (inst_valid_o),
    .mem_stall_o     (mem_stall_o),
    .flush_o         (flush_o),
    .miss_cycles_o   (miss_cycles_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: inputs change 1 time unit after the edge, outputs sampled 1 unit later
  task automatic cyc(input logic ack, input logic [31:0] data, input logic stall,
                     input logic br, input logic [31:0] tgt, input logic halt);
    icache_ack_i    = ack;
    icache_data_i   = data;
    stall_i         = stall;
    branch_i        = br;
    branch_target_i = tgt;
    halt_i          = halt;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i  = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    #1;
    check("rst_req",    32'(icache_req_o),  32'h0);
    check("rst_valid",  32'(inst_valid_o),  32'h0);
    check("rst_inst",   inst_o,             32'h0);
    check("rst_pc",     pc_o,               32'h0);
    check("rst_add4",   pc_add4_o,          32'h4);
    check("rst_mstall", 32'(mem_stall_o),   32'h0);
    check("rst_flush",  32'(flush_o),       32'h0);
    check("rst_miss",   32'(miss_cycles_o), 32'h0);

    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b1;

    // IDLE cycle: a stray ack must not produce an instruction
    cyc(1, 32'hDEAD_BEEF, 0, 0, 0, 0);
    check("idle_req",   32'(icache_req_o), 32'h0);
    check("idle_valid", 32'(inst_valid_o), 32'h0);
    step();

    // hits at 0, then 4 with a decode stall
    cyc(1, 32'h0, 0, 0, 0, 0);
    check("hit0_req",   32'(icache_req_o), 32'h1);
    check("hit0_addr",  icache_addr_o,     32'h0);
    check("hit0_valid", 32'(inst_valid_o), 32'h1);
    check("hit0_add4",  pc_add4_o,         32'h4);
    step();
    cyc(1, 32'h4, 1, 0, 0, 0);
    check("hit4_addr",  icache_addr_o,     32'h4);
    check("hit4_inst",  inst_o,            32'h4);
    check("hit4_valid", 32'(inst_valid_o), 32'h1);
    step();

    // HOLD: stall still high, then released
    cyc(0, 32'h0, 1, 0, 0, 0);
    check("hold_req",   32'(icache_req_o), 32'h0);
    check("hold_inst",  inst_o,            32'h4);
    check("hold_valid", 32'(inst_valid_o), 32'h1);
    check("hold_pc",    pc_o,              32'h4);
    step();
    cyc(0, 32'h0, 0, 0, 0, 0);
    check("rel_req",  32'(icache_req_o), 32'h0);
    check("rel_inst", inst_o,            32'h4);
    step();

    // 3-cycle miss at pc=8
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h0, 0, 0, 0, 0);
      check("miss8_stall", 32'(mem_stall_o),  32'h1);
      check("miss8_addr",  icache_addr_o,     32'h8);
      check("miss8_valid", 32'(inst_valid_o), 32'h0);
      step();
    end
    cyc(1, 32'h8, 0, 0, 0, 0);
    check("miss8_inst", inst_o,             32'h8);
    check("miss8_cnt",  32'(miss_cycles_o), 32'h3);
    check("miss8_ms",   32'(mem_stall_o),   32'h0);
    step();
    cyc(1, 32'hC, 0, 0, 0, 0);
    check("hit12_addr", icache_addr_o, 32'hC);
    check("hit12_add4", pc_add4_o,     32'h10);
    step();

    // branch to 0x100 during miss at 16
    cyc(0, 32'h0, 0, 1, 32'h100, 0);
    check("brm_flush", 32'(flush_o),     32'h1);
    check("brm_stall", 32'(mem_stall_o), 32'h1);
    check("brm_addr",  icache_addr_o,    32'h10);
    step();
    cyc(0, 32'h0, 0, 0, 0, 0);
    check("brm_flush2", 32'(flush_o),  32'h0);
    check("brm_addr2",  icache_addr_o, 32'h10);
    step();
    cyc(1, 32'h10, 0, 0, 0, 0);
    check("brm_drop",  32'(inst_valid_o), 32'h0);
    check("brm_flush3", 32'(flush_o),     32'h0);
    step();

    // hit at 0x100 with stall -> HOLD, then branch to 0x40 while stalled
    cyc(1, 32'h100, 1, 0, 0, 0);
    check("t100_addr", icache_addr_o, 32'h100);
    check("t100_inst", inst_o,        32'h100);
    step();
    cyc(0, 32'h0, 1, 1, 32'h40, 0);
    check("hbr_flush", 32'(flush_o),      32'h1);
    check("hbr_valid", 32'(inst_valid_o), 32'h0);
    check("hbr_req",   32'(icache_req_o), 32'h0);
    step();

    // hit at 0x40 with a branch to the last word, then wrap
    cyc(1, 32'h40, 0, 1, 32'hFFFF_FFFC, 0);
    check("t40_addr",  icache_addr_o,     32'h40);
    check("t40_flush", 32'(flush_o),      32'h1);
    check("t40_valid", 32'(inst_valid_o), 32'h0);
    step();
    cyc(1, 32'h1234, 0, 0, 0, 0);
    check("wrap_addr", icache_addr_o, 32'hFFFF_FFFC);
    check("wrap_add4", pc_add4_o,     32'h0);
    check("wrap_inst", inst_o,        32'h1234);
    step();
    cyc(1, 32'h0, 0, 0, 0, 0);
    check("wrap_next", icache_addr_o, 32'h0);
    step();

    // halt during miss at pc=4; branch while halt pending is ignored
    cyc(0, 32'h0, 0, 0, 0, 1);
    check("hlt_stall", 32'(mem_stall_o), 32'h1);
    check("hlt_addr",  icache_addr_o,    32'h4);
    step();
    cyc(0, 32'h0, 0, 1, 32'h200, 0);
    check("hlt_noflush", 32'(flush_o),      32'h0);
    check("hlt_req",     32'(icache_req_o), 32'h1);
    step();
    cyc(1, 32'h4, 0, 0, 0, 0);
    check("hlt_drop", 32'(inst_valid_o), 32'h0);
    check("hlt_flsh", 32'(flush_o),      32'h0);
    step();
    cyc(1, 32'h8, 0, 0, 0, 0);
    check("halted_req",   32'(icache_req_o),  32'h0);
    check("halted_valid", 32'(inst_valid_o),  32'h0);
    check("halted_inst",  inst_o,             32'h0);
    check("halted_pc",    pc_o,               32'h4);
    check("halted_miss",  32'(miss_cycles_o), 32'h7);
    step();
    cyc(0, 32'h0, 0, 0, 0, 0);
    check("halted_req2", 32'(icache_req_o), 32'h0);
    check("halted_pc2",  pc_o,              32'h4);

    // asynchronous reset mid-cycle
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_pc",   pc_o,               32'h0);
    check("arst_add4", pc_add4_o,          32'h4);
    check("arst_miss", 32'(miss_cycles_o), 32'h0);
    check("arst_req",  32'(icache_req_o),  32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    cyc(0, 32'h0, 0, 0, 0, 0);
    check("arst_idle", 32'(icache_req_o), 32'h0);
    step();
    check("arst_req1",  32'(icache_req_o), 32'h1);
    check("arst_addr1", icache_addr_o,     32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline latch. It owns the program counter, issues one request per instruction to the L1 instruction cache, and absorbs variable hit/miss latency. It buffers a fetched instruction while the pipeline is stalled, applies branch redirects (including redirects that arrive during an outstanding miss), and presents the instruction and PC+4 to IF/ID each cycle.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the saturating miss-cycle counter

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- stall_i  in  1  hazard stall from decode; hold the current instruction
- branch_i  in  1  redirect request, valid for one cycle
- branch_target_i  in  32  redirect target PC
- halt_i  in  1  stop fetching (sticky once taken)
- icache_req_o  out  1  fetch request; held with stable address until ack
- icache_addr_o  out  32  fetch address (= pc_o)
- icache_ack_i  in  1  data valid this cycle (same cycle as req on hit)
- icache_data_i  in  32  instruction word
- pc_o  out  32  current PC
- pc_add4_o  out  32  pc_o + 4, modulo 2^32
- inst_o  out  32  instruction to IF/ID; 0 (NOP) when inst_valid_o=0
- inst_valid_o  out  1  inst_o holds a real instruction
- mem_stall_o  out  1  request outstanding without ack; freezes downstream
- flush_o  out  1  pulse: IF/ID must load a NOP
- miss_cycles_o  out  CNT_W  saturating count of cycles with mem_stall_o=1

## Operation
- States: IDLE, REQ, HOLD, HALTED. Registers: pc, buf_inst, redir_pend, redir_pc, miss_cnt.
- IDLE: entered on reset; all requests deasserted; next state is REQ.
- REQ: icache_req_o=1, icache_addr_o=pc.
  - ack=0: mem_stall_o=1, miss_cnt+1 (saturating at all-ones), stay in REQ, and keep the address unchanged.
  - ack=1 with redir_pend=1: discard the data (inst_valid_o=0), pc<=redir_pc, clear redir_pend, stay in REQ.
  - ack=1 and branch_i: discard the data, flush_o=1, pc<=branch_target_i, stay in REQ.
  - ack=1, no stall_i: inst_o=icache_data_i, inst_valid_o=1, pc<=pc+4, stay in REQ.
  - ack=1 with stall_i: inst_o=icache_data_i and inst_valid_o=1; buf_inst<=data; go to HOLD with pc unchanged.
  - branch_i with ack=0: flush_o=1, redir_pend<=1, redir_pc<=branch_target_i. The request stays up at the old address. A later branch overwrites redir_pc.
- HOLD: icache_req_o=0, inst_o=buf_inst, inst_valid_o=1.
  - branch_i: flush_o=1, pc<=target, go to REQ. A branch has priority over stall_i.
  - stall_i=0: pc<=pc+4, go to REQ.
  - Otherwise: stay in HOLD.
- HALTED: req=0, inst_valid_o=0, inst_o=0, pc frozen. Only reset exits this state.
- halt_i handling:
  - Sampled in IDLE, HOLD, or REQ with ack=1: the next state is HALTED, and any data present that cycle is discarded.
  - Sampled in REQ with ack=0: the halt is latched; the block waits for ack, discards the data, then enters HALTED.
  - halt_i suppresses flush_o and branch redirects.
- inst_o, inst_valid_o, flush_o, and mem_stall_o are combinational from state and inputs. pc_o, pc_add4_o, and miss_cycles_o are registered or derived from registers.
- Reset (asynchronous, rst_i=0): pc=RESET_PC, state=IDLE, redir_pend=0, buf_inst=0, miss_cnt=0. While in reset: icache_req_o=0, inst_o=0, inst_valid_o=0, mem_stall_o=0, flush_o=0, pc_add4_o=RESET_PC+4. Reset during an outstanding miss abandons the request; a late ack is ignored in IDLE.

## Timing
- First request is issued in the second cycle after reset release (IDLE for one cycle).
- Hit throughput: one instruction per cycle. Latency: request and data are in the same cycle, so IF/ID captures at the next edge.
- A miss of N cycles gives N cycles of mem_stall_o=1 and adds N to miss_cnt. The instruction appears in the ack cycle.
- Redirect: target request is issued the cycle after branch_i (or after a pending ack). Exactly one flush_o pulse per accepted branch.
- pc+4 wraps: pc=32'hFFFF_FFFC produces next pc=0.

## Test plan
- Reset release, always-hit cache returning pc as data: addresses 0,4,8,12 on consecutive cycles; inst_valid_o=1 from cycle 2; pc_add4_o=pc+4.
- 3-cycle miss at pc=8: mem_stall_o=1 for 3 cycles, address held at 8, miss_cycles_o=3, then the instruction at 8 is issued and pc becomes 12.
- stall_i high for 2 cycles on the ack of pc=4: HOLD keeps inst_o=data(4) with no requests; after release, the next request is 8.
- branch_i to 0x100 during the miss at pc=16: flush_o pulses once, the request stays at 16 until ack, data(16) is dropped, and the next request is 0x100.
- branch_i to 0x40 while in HOLD with stall_i=1: the buffer is discarded, flush_o=1, and the next request is 0x40.
- halt_i during a miss, then reset asserted mid-run: HALTED only after ack, with no further requests. Asynchronous reset returns all outputs to reset values immediately, and pc=RESET_PC.
